// File: rtl/register_preloader.sv
// Loads sp and the a0..a(N-1) argument registers into a core's register file,
// releases the core to run, and reports completion when the core halts.
//
// state     | meaning
// IDLE      | host stages argument words; waits for start
// LOAD_SP   | sp write issued on the next cycle
// LOAD_ARGS | one argument register write per cycle, a0 upward
// RUN       | core released; waits for core_halt
module register_preloader #(
  parameter int          NUM_ARGS = 8,
  parameter logic [31:0] SP_INIT  = 32'h0000_FFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arg_valid,
  output logic        arg_ready,
  input  logic [2:0]  arg_index,
  input  logic [31:0] arg_data,
  input  logic        start,
  input  logic        core_halt,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_value,
  output logic        wr_enable,
  output logic        core_run,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = (NUM_ARGS + 1 > 2) ? $clog2(NUM_ARGS + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_SP, LOAD_ARGS, RUN} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [31:0]        slot_data [NUM_ARGS];
  logic [NUM_ARGS-1:0] staged;
  logic               accept;
  logic               last_arg;
  logic               halt_now;
  logic [31:0]        cur_arg;
  logic               wr_enable_d;
  logic [4:0]         wr_addr_d;
  logic [31:0]        wr_value_d;

  assign accept   = arg_valid & arg_ready;
  assign last_arg = (cnt == CNT_W'(NUM_ARGS - 1));
  assign halt_now = (state == RUN) & core_halt;

  // Unstaged slots load as zero even if stale data were present.
  always_comb begin
    cur_arg = '0;
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (cnt == CNT_W'(i) && staged[i]) cur_arg = slot_data[i];
    end
  end

  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD_SP;
        cnt_d = '0;
      end
      LOAD_SP: begin
        next_state = LOAD_ARGS;
        cnt_d      = '0;
      end
      LOAD_ARGS: begin
        if (last_arg) begin
          next_state = RUN;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (core_halt) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Write port is registered from the current state, so each write appears
  // one cycle after the state that issues it.
  always_comb begin
    wr_enable_d = 1'b0;
    wr_addr_d   = '0;
    wr_value_d  = '0;
    case (state)
      LOAD_SP: begin
        wr_enable_d = 1'b1;
        wr_addr_d   = 5'd2;
        wr_value_d  = SP_INIT;
      end
      LOAD_ARGS: begin
        wr_enable_d = 1'b1;
        wr_addr_d   = 5'd10 + 5'(cnt);
        wr_value_d  = cur_arg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_enable <= 1'b0;
      wr_addr   <= '0;
      wr_value  <= '0;
      core_run  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      arg_ready <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_d;
      wr_enable <= wr_enable_d;
      wr_addr   <= wr_addr_d;
      wr_value  <= wr_value_d;
      core_run  <= (state == RUN) & ~core_halt;
      done      <= halt_now;
      busy      <= (next_state != IDLE);
      arg_ready <= (next_state == IDLE);
    end
  end

  // Out-of-range indices match no slot and are silently dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      staged <= '0;
      for (int i = 0; i < NUM_ARGS; i++) slot_data[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (halt_now) begin
          staged[i]    <= 1'b0;
          slot_data[i] <= '0;
        end else if (accept && arg_index == 3'(i)) begin
          staged[i]    <= 1'b1;
          slot_data[i] <= arg_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_register_preloader.sv
// Directed bench for register_preloader: an 8-argument instance for the main
// sequences and a 2-argument instance for out-of-range slot handling.
module tb_register_preloader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        arg_valid, start, core_halt;
  logic [2:0]  arg_index;
  logic [31:0] arg_data;
  logic        arg_ready, wr_enable, core_run, busy, done;
  logic [4:0]  wr_addr;
  logic [31:0] wr_value;

  logic        arg_valid2, start2, core_halt2;
  logic [2:0]  arg_index2;
  logic [31:0] arg_data2;
  logic        arg_ready2, wr_enable2, core_run2, busy2, done2;
  logic [4:0]  wr_addr2;
  logic [31:0] wr_value2;

  int n_checks = 0;
  int n_fail   = 0;

  register_preloader dut (
    .clk(clk), .rst_n(rst_n), .arg_valid(arg_valid), .arg_ready(arg_ready),
    .arg_index(arg_index), .arg_data(arg_data), .start(start), .core_halt(core_halt),
    .wr_addr(wr_addr), .wr_value(wr_value), .wr_enable(wr_enable),
    .core_run(core_run), .busy(busy), .done(done)
  );

  register_preloader #(.NUM_ARGS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .arg_valid(arg_valid2), .arg_ready(arg_ready2),
    .arg_index(arg_index2), .arg_data(arg_data2), .start(start2), .core_halt(core_halt2),
    .wr_addr(wr_addr2), .wr_value(wr_value2), .wr_enable(wr_enable2),
    .core_run(core_run2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [31:0] exp1 [8] = '{32'h5, 32'hA, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] exp3 [8] = '{32'h2, 32'h0, 32'h0, 32'h77, 32'h0, 32'h0, 32'h0, 32'h0};

  initial begin
    rst_n = 1'b0;
    arg_valid = 0; arg_index = '0; arg_data = '0; start = 0; core_halt = 0;
    arg_valid2 = 0; arg_index2 = '0; arg_data2 = '0; start2 = 0; core_halt2 = 0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_arg_ready", arg_ready, 0);
    chk("rst_wr", {wr_enable, wr_addr, wr_value}, 0);
    chk("rst_core_run", core_run, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_arg_ready", arg_ready, 1);
    chk("post_rst_busy", busy, 0);

    // 2-argument instance: index 5 must be dropped
    arg_valid2 = 1; arg_index2 = 3'd5; arg_data2 = 32'hDEAD;
    tick();
    arg_index2 = 3'd1; arg_data2 = 32'h11;
    tick();
    arg_valid2 = 0; start2 = 1;
    tick();
    start2 = 0;
    chk("n2_busy", busy2, 1);
    tick();
    chk("n2_sp", {wr_enable2, wr_addr2, wr_value2}, {1'b1, 5'd2, 32'h0000_FFF0});
    tick();
    chk("n2_x10", {wr_enable2, wr_addr2, wr_value2}, {1'b1, 5'd10, 32'h0});
    tick();
    chk("n2_x11", {wr_enable2, wr_addr2, wr_value2}, {1'b1, 5'd11, 32'h11});
    tick();
    chk("n2_wr_off", {wr_enable2, wr_addr2, wr_value2}, 0);
    chk("n2_core_run", core_run2, 1);

    // Sequence 1: a0=5, a1=A
    arg_valid = 1; arg_index = 3'd0; arg_data = 32'h5;
    tick();
    arg_index = 3'd1; arg_data = 32'hA;
    tick();
    arg_valid = 0; start = 1;
    tick();
    start = 0;
    chk("s1_busy", busy, 1);
    chk("s1_arg_ready", arg_ready, 0);
    chk("s1_no_wr_yet", wr_enable, 0);
    tick();
    chk("s1_sp", {wr_enable, wr_addr, wr_value}, {1'b1, 5'd2, 32'h0000_FFF0});
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("s1_x%0d", 10 + i), {wr_enable, wr_addr, wr_value}, {1'b1, 5'(10 + i), exp1[i]});
    end
    chk("s1_run_not_yet", core_run, 0);
    tick();
    chk("s1_wr_off", {wr_enable, wr_addr, wr_value}, 0);
    chk("s1_core_run", core_run, 1);
    chk("s1_done_low", done, 0);

    core_halt = 1;
    tick();
    core_halt = 0;
    chk("h1_core_run", core_run, 0);
    chk("h1_done", done, 1);
    chk("h1_busy", busy, 0);
    chk("h1_arg_ready", arg_ready, 1);
    tick();
    chk("h1_done_one_cycle", done, 0);

    // Sequence 2: nothing staged; start/halt during LOAD_SP; arg during LOAD_ARGS
    start = 1;
    tick();
    core_halt = 1;
    chk("s2_no_wr_yet", wr_enable, 0);
    tick();
    start = 0; core_halt = 0;
    chk("s2_sp", {wr_enable, wr_addr, wr_value}, {1'b1, 5'd2, 32'h0000_FFF0});
    chk("s2_busy", busy, 1);
    arg_valid = 1; arg_index = 3'd2; arg_data = 32'h99;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("s2_x%0d", 10 + i), {wr_enable, wr_addr, wr_value}, {1'b1, 5'(10 + i), 32'h0});
    end
    chk("s2_arg_ready_low", arg_ready, 0);
    arg_valid = 0;
    tick();
    chk("s2_core_run", core_run, 1);
    tick();
    chk("s2_core_run_held", core_run, 1);
    chk("s2_done_low", done, 0);
    core_halt = 1;
    tick();
    core_halt = 0;
    chk("h2_done", done, 1);
    tick();

    // Sequence 3: slot 0 overwritten, slot 3 staged in the start cycle
    arg_valid = 1; arg_index = 3'd0; arg_data = 32'h1;
    tick();
    arg_data = 32'h2;
    tick();
    arg_index = 3'd3; arg_data = 32'h77; start = 1;
    tick();
    arg_valid = 0; start = 0;
    tick();
    chk("s3_sp", {wr_enable, wr_addr, wr_value}, {1'b1, 5'd2, 32'h0000_FFF0});
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("s3_x%0d", 10 + i), {wr_enable, wr_addr, wr_value}, {1'b1, 5'(10 + i), exp3[i]});
    end
    tick();
    chk("s3_core_run", core_run, 1);
    core_halt = 1;
    tick();
    core_halt = 0;
    chk("h3_done", done, 1);
    tick();

    // Sequence 4: reset during the third argument write
    arg_valid = 1; arg_index = 3'd0; arg_data = 32'h3;
    tick();
    arg_valid = 0; start = 1;
    tick();
    start = 0;
    tick();
    tick();
    chk("s4_x10", {wr_enable, wr_addr, wr_value}, {1'b1, 5'd10, 32'h3});
    tick();
    tick();
    chk("s4_x12", {wr_enable, wr_addr, wr_value}, {1'b1, 5'd12, 32'h0});
    #1 rst_n = 1'b0;
    #1;
    chk("r4_wr_async", {wr_enable, wr_addr, wr_value}, 0);
    chk("r4_core_run", core_run, 0);
    chk("r4_busy", busy, 0);
    chk("r4_arg_ready", arg_ready, 0);
    tick();
    tick();
    chk("r4_wr_held", wr_enable, 0);
    chk("r4_no_done", done, 0);
    rst_n = 1'b1;
    tick();
    chk("r4_arg_ready_after", arg_ready, 1);
    chk("r4_busy_after", busy, 0);
    chk("r4_done_after", done, 0);
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    chk("r4_slot_cleared", {wr_enable, wr_addr, wr_value}, {1'b1, 5'd10, 32'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_preloader.md
REGISTER_PRELOADER -- requirements
Module: register_preloader

Interface
REQ-001 Parameter NUM_ARGS, default 8, number of argument registers loaded starting at x10 (a0); legal range 1..8.
REQ-002 Parameter SP_INIT, default 32'h0000_FFF0, value written to x2 (sp) before arguments.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 arg_valid  input  1  host offers an argument word.
REQ-006 arg_ready  output  1  block accepts an argument word this cycle.
REQ-007 arg_index  input  3  argument slot (0 = a0 ... 7 = a7).
REQ-008 arg_data  input  32  argument value.
REQ-009 start  input  1  single-cycle request to begin the register-load sequence.
REQ-010 core_halt  input  1  core reports program finished.
REQ-011 wr_addr  output  5  register-file write address to core.
REQ-012 wr_value  output  32  register-file write data to core.
REQ-013 wr_enable  output  1  register-file write strobe, one write per cycle.
REQ-014 core_run  output  1  core released to execute.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse when a run completes.

Function
REQ-017 FSM states SHALL be IDLE, LOAD_SP, LOAD_ARGS, RUN; all outputs registered.
REQ-018 arg_ready SHALL be 1 in IDLE and 0 in all other states.
REQ-019 A handshake (arg_valid & arg_ready) SHALL store arg_data in slot arg_index and set that slot's staged bit; repeated writes to a slot: last one wins.
REQ-020 A handshake with arg_index >= NUM_ARGS SHALL be accepted and discarded with no state change.
REQ-021 start in IDLE SHALL move to LOAD_SP; start in any other state SHALL be ignored.
REQ-022 arg handshake and start in the same IDLE cycle: the argument SHALL be stored and included in the load sequence.
REQ-023 LOAD_SP SHALL last one cycle: wr_enable=1, wr_addr=5'd2, wr_value=SP_INIT; then LOAD_ARGS with counter=0.
REQ-024 LOAD_ARGS SHALL issue one write per cycle, wr_addr=10+counter, wr_value=slot data if staged else 32'h0, for counter 0..NUM_ARGS-1, then RUN.
REQ-025 Timing: start sampled at edge N -> sp write visible after edge N+1, arg i write after edge N+2+i, core_run=1 after edge N+2+NUM_ARGS.
REQ-026 wr_enable SHALL be 0 outside LOAD_SP/LOAD_ARGS; wr_addr/wr_value SHALL be 0 when wr_enable=0.
REQ-027 RUN SHALL hold core_run=1 until core_halt=1 is sampled; core_halt outside RUN SHALL be ignored.
REQ-028 On core_halt in RUN: next cycle core_run=0, done=1 for exactly one cycle, state IDLE, all staged bits and slot data cleared.
REQ-029 Slot writes SHALL not occur outside IDLE, so values loaded in a sequence are those staged at start.
REQ-030 Argument counter SHALL be width ceil(log2(NUM_ARGS+1)) minimum 1 bit; no wrap beyond NUM_ARGS-1.

Reset
REQ-031 rst_n low SHALL immediately (asynchronously) force state IDLE, core_run=0, wr_enable=0, wr_addr=0, wr_value=0, busy=0, done=0, arg_ready=0 while asserted, counter=0, all slots and staged bits 0.
REQ-032 After rst_n rises, arg_ready SHALL be 1 on the first cycle in IDLE.
REQ-033 Reset asserted mid-LOAD_ARGS or in RUN SHALL abort with no further writes and core_run low; no done pulse.

Verification
REQ-034 Stage a0=32'h5, a1=32'hA, then start -> writes x2=32'h0000_FFF0, x10=5, x11=A, x12..x17=0 on consecutive cycles, then core_run=1 (NUM_ARGS=8).
REQ-035 arg_valid with index 3 data 32'h77 in the same cycle as start -> x13 written 32'h77; arg during LOAD_ARGS -> arg_ready=0, ignored.
REQ-036 Two writes to slot 0 (32'h1 then 32'h2) -> x10 written 32'h2 only; NUM_ARGS=2 with index 5 -> discarded, only x10,x11 written.
REQ-037 In RUN, pulse core_halt -> core_run falls, done high one cycle, busy=0; next start with no staging -> all argument writes 32'h0.
REQ-038 rst_n low during LOAD_ARGS third write -> wr_enable and core_run 0 immediately, no done; after release idle with arg_ready=1.
REQ-039 start and core_halt pulsed during LOAD_SP -> both ignored, sequence completes normally into RUN.
